// File: rtl/sound_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : sound_mailbox (with helper sound_mailbox_fifo)
//  Description : Bidirectional main/sound CPU mailbox. Two independent
//                DEPTH x WIDTH FIFOs with registered head data, optional
//                overwrite-when-full, sticky overflow flags and a sound-CPU
//                interrupt that is either level (m2s non-empty) or latched.
//  Revision    : 1.0 - initial release
// ============================================================================

module sound_mailbox_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    push_evt,
    output logic                    ovf_evt
);
    // A one-entry FIFO still needs a one-bit pointer; it simply never moves.
    localparam int                   c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                   c_CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [c_PTR_W-1:0]   c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_dout;

    logic               w_empty;
    logic               w_full;
    logic               w_pop_ok;
    logic               w_push_ok;
    logic               w_ovr;
    logic               w_wr_en;
    logic [c_PTR_W-1:0] w_rd_nxt;
    logic [c_PTR_W-1:0] w_wr_nxt;
    logic [c_PTR_W-1:0] w_wr_prev;
    logic [c_PTR_W-1:0] w_wr_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_pop_ok  = pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push_ok = push & (~w_full | w_pop_ok);
    assign ovf_evt   = push & w_full & ~w_pop_ok;
    assign w_ovr     = ovf_evt & (OVERWRITE != 0);

    assign w_rd_nxt  = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
    assign w_wr_nxt  = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_wr_prev = (r_wr_ptr == '0) ? c_PTR_LAST : r_wr_ptr - 1'b1;

    // Overwrite targets the newest entry, which sits just behind the write pointer.
    assign w_wr_en   = w_push_ok | w_ovr;
    assign w_wr_idx  = w_ovr ? w_wr_prev : r_wr_ptr;
    assign push_evt  = w_wr_en;

    assign dout      = r_dout;
    assign count     = r_count;

    // Storage array; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk_sys) begin
        if (reset_n && w_wr_en) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    // Pointers, occupancy and the registered head-of-queue value.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_nxt;
            end
            if (w_push_ok) begin
                r_wr_ptr <= w_wr_nxt;
            end

            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end

            // Head tracking: the new head is either incoming data or the entry
            // after the one being popped; an emptied FIFO keeps the last value.
            if (w_empty && w_push_ok) begin
                r_dout <= din;
            end else if (w_pop_ok) begin
                if (r_count == c_CNT_ONE) begin
                    if (w_push_ok) begin
                        r_dout <= din;
                    end
                end else begin
                    r_dout <= r_mem[w_rd_nxt];
                end
            end else if (w_ovr && (w_wr_prev == r_rd_ptr)) begin
                r_dout <= din;
            end
        end
    end
endmodule

module sound_mailbox #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int OVERWRITE = 0,
    parameter int IRQ_MODE  = 0
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    main_wr,
    input  logic [WIDTH-1:0]        main_din,
    input  logic                    main_rd,
    output logic [WIDTH-1:0]        main_dout,
    output logic                    main_rdy,
    output logic                    main_full,
    input  logic                    snd_wr,
    input  logic [WIDTH-1:0]        snd_din,
    input  logic                    snd_rd,
    output logic [WIDTH-1:0]        snd_dout,
    output logic                    snd_rdy,
    output logic                    snd_full,
    output logic [$clog2(DEPTH):0]  m2s_count,
    output logic [$clog2(DEPTH):0]  s2m_count,
    output logic                    snd_irq_n,
    input  logic                    snd_irq_ack,
    output logic [1:0]              ovf,
    input  logic                    clr_ovf
);
    localparam int                 c_CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    logic       w_m2s_push;
    logic       w_m2s_ovf;
    logic       w_s2m_push;
    logic       w_s2m_ovf;
    logic [1:0] r_ovf;
    logic       r_pending;

    // Main CPU writes, sound CPU reads.
    sound_mailbox_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_m2s (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .push     (main_wr),
        .din      (main_din),
        .pop      (snd_rd),
        .dout     (snd_dout),
        .count    (m2s_count),
        .push_evt (w_m2s_push),
        .ovf_evt  (w_m2s_ovf)
    );

    // Sound CPU writes, main CPU reads.
    sound_mailbox_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_s2m (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .push     (snd_wr),
        .din      (snd_din),
        .pop      (main_rd),
        .dout     (main_dout),
        .count    (s2m_count),
        .push_evt (w_s2m_push),
        .ovf_evt  (w_s2m_ovf)
    );

    // Status decodes of the registered counts.
    assign snd_rdy   = (m2s_count != '0);
    assign main_rdy  = (s2m_count != '0);
    assign main_full = (m2s_count == c_CNT_FULL);
    assign snd_full  = (s2m_count == c_CNT_FULL);
    assign ovf       = r_ovf;

    // The latched pending flag exists in both modes; only IRQ_MODE selects it.
    assign snd_irq_n = (IRQ_MODE != 0) ? ~r_pending : ~snd_rdy;

    // Sticky overflow flags and latched IRQ; a new event beats its clear.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_ovf     <= 2'b00;
            r_pending <= 1'b0;
        end else begin
            r_ovf[0]  <= w_m2s_ovf | (r_ovf[0] & ~clr_ovf);
            r_ovf[1]  <= w_s2m_ovf | (r_ovf[1] & ~clr_ovf);
            r_pending <= w_m2s_push | (r_pending & ~snd_irq_ack);
        end
    end

    // Only the m2s push event feeds the IRQ; the s2m one is informational.
    logic w_unused;
    assign w_unused = w_s2m_push;
endmodule

`default_nettype wire

// File: tb/tb_sound_mailbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sound_mailbox
//  Description : Self-checking bench for sound_mailbox. Three configurations
//                share one stimulus bus: 0 = DEPTH4/drop/level IRQ,
//                1 = DEPTH1/overwrite/latched IRQ, 2 = DEPTH4/overwrite/latched.
//                A queue-based model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_mailbox;
    localparam int c_N = 3;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       reset_n, main_wr, main_rd, snd_wr, snd_rd, snd_irq_ack, clr_ovf;
    logic [7:0] main_din, snd_din;

    logic [7:0] a_mdout [c_N];
    logic [7:0] a_sdout [c_N];
    logic       a_mrdy  [c_N];
    logic       a_mfull [c_N];
    logic       a_srdy  [c_N];
    logic       a_sfull [c_N];
    logic       a_irqn  [c_N];
    logic [2:0] a_mcnt  [c_N];
    logic [2:0] a_scnt  [c_N];
    logic [1:0] a_ovf   [c_N];

    for (genvar g = 0; g < c_N; g++) begin : g_dut
        localparam int D  = (g == 1) ? 1 : 4;
        localparam int CW = $clog2(D) + 1;
        logic [7:0]    md, sd;
        logic          mr, mf, sr, sf, irqn;
        logic [CW-1:0] mc, sc;
        logic [1:0]    ov;

        sound_mailbox #(
            .WIDTH     (8),
            .DEPTH     (D),
            .OVERWRITE ((g == 0) ? 0 : 1),
            .IRQ_MODE  ((g == 0) ? 0 : 1)
        ) u_dut (
            .clk_sys     (clk_sys),
            .reset_n     (reset_n),
            .main_wr     (main_wr),
            .main_din    (main_din),
            .main_rd     (main_rd),
            .main_dout   (md),
            .main_rdy    (mr),
            .main_full   (mf),
            .snd_wr      (snd_wr),
            .snd_din     (snd_din),
            .snd_rd      (snd_rd),
            .snd_dout    (sd),
            .snd_rdy     (sr),
            .snd_full    (sf),
            .m2s_count   (mc),
            .s2m_count   (sc),
            .snd_irq_n   (irqn),
            .snd_irq_ack (snd_irq_ack),
            .ovf         (ov),
            .clr_ovf     (clr_ovf)
        );

        assign a_mdout[g] = md;
        assign a_sdout[g] = sd;
        assign a_mrdy[g]  = mr;
        assign a_mfull[g] = mf;
        assign a_srdy[g]  = sr;
        assign a_sfull[g] = sf;
        assign a_irqn[g]  = irqn;
        assign a_mcnt[g]  = 3'(mc);
        assign a_scnt[g]  = 3'(sc);
        assign a_ovf[g]   = ov;
    end

    // ------------------------------------------------------------------
    // Reference model: queue index k = 2*inst + dir (dir 0 = m2s, 1 = s2m)
    // ------------------------------------------------------------------
    logic [7:0] mq     [2*c_N][$];
    logic [7:0] m_last [2*c_N];
    logic [1:0] m_ovf  [c_N];
    logic       m_pend [c_N];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    function automatic int dep(input int i);
        return (i == 1) ? 1 : 4;
    endfunction
    function automatic bit ow(input int i);
        return (i != 0);
    endfunction
    function automatic bit irqm(input int i);
        return (i != 0);
    endfunction

    task automatic fifo_step(input int k, input int d, input bit owr, input logic push,
                             input logic pop, input logic [7:0] din,
                             output bit ev_push, output bit ev_ovf);
        int n      = mq[k].size();
        bit pop_ok = pop && (n > 0);
        ev_push = 1'b0;
        ev_ovf  = 1'b0;
        if (pop_ok) m_last[k] = mq[k].pop_front();
        if (push) begin
            if (n < d || pop_ok) begin
                mq[k].push_back(din);
                ev_push = 1'b1;
            end else begin
                ev_ovf = 1'b1;
                if (owr) begin
                    mq[k][mq[k].size()-1] = din;
                    ev_push = 1'b1;
                end
            end
        end
    endtask

    task automatic model_step();
        bit e0p, e0o, e1p, e1o;
        for (int i = 0; i < c_N; i++) begin
            if (!reset_n) begin
                mq[2*i].delete();
                mq[2*i+1].delete();
                m_last[2*i]   = 8'h00;
                m_last[2*i+1] = 8'h00;
                m_ovf[i]      = 2'b00;
                m_pend[i]     = 1'b0;
            end else begin
                fifo_step(2*i,   dep(i), ow(i), main_wr, snd_rd,  main_din, e0p, e0o);
                fifo_step(2*i+1, dep(i), ow(i), snd_wr,  main_rd, snd_din,  e1p, e1o);
                if (e0o) m_ovf[i][0] = 1'b1; else if (clr_ovf) m_ovf[i][0] = 1'b0;
                if (e1o) m_ovf[i][1] = 1'b1; else if (clr_ovf) m_ovf[i][1] = 1'b0;
                if (e0p) m_pend[i] = 1'b1; else if (snd_irq_ack) m_pend[i] = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk_sys);
        model_step();
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int i);
        int nm = mq[2*i].size();
        int ns = mq[2*i+1].size();
        chk("snd_dout",  i, 32'(a_sdout[i]), (nm > 0) ? 32'(mq[2*i][0])   : 32'(m_last[2*i]));
        chk("main_dout", i, 32'(a_mdout[i]), (ns > 0) ? 32'(mq[2*i+1][0]) : 32'(m_last[2*i+1]));
        chk("m2s_count", i, 32'(a_mcnt[i]),  32'(nm));
        chk("s2m_count", i, 32'(a_scnt[i]),  32'(ns));
        chk("snd_rdy",   i, 32'(a_srdy[i]),  32'(nm != 0));
        chk("main_rdy",  i, 32'(a_mrdy[i]),  32'(ns != 0));
        chk("main_full", i, 32'(a_mfull[i]), 32'(nm == dep(i)));
        chk("snd_full",  i, 32'(a_sfull[i]), 32'(ns == dep(i)));
        chk("ovf",       i, 32'(a_ovf[i]),   32'(m_ovf[i]));
        chk("snd_irq_n", i, 32'(a_irqn[i]),  irqm(i) ? 32'(!m_pend[i]) : 32'(nm == 0));
    endtask

    // Per-cycle comparison on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk_sys);
        if (chk_en) begin
            for (int i = 0; i < c_N; i++) check_inst(i);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: apply for one rising edge, then return to idle.
    // ------------------------------------------------------------------
    task automatic drive(input logic mw, input logic [7:0] md, input logic sr,
                         input logic sw, input logic [7:0] sd, input logic mr,
                         input logic ack, input logic clr, input logic rn);
        main_wr = mw; main_din = md; snd_rd = sr;
        snd_wr = sw; snd_din = sd; main_rd = mr;
        snd_irq_ack = ack; clr_ovf = clr; reset_n = rn;
        @(posedge clk_sys);
        #1;
        main_wr = 1'b0; snd_rd = 1'b0; snd_wr = 1'b0; main_rd = 1'b0;
        snd_irq_ack = 1'b0; clr_ovf = 1'b0; reset_n = 1'b1;
    endtask

    task automatic push_m(input logic [7:0] v);
        drive(1'b1, v, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask
    task automatic pop_s();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask
    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; main_wr = 1'b0; main_rd = 1'b0; snd_wr = 1'b0; snd_rd = 1'b0;
        snd_irq_ack = 1'b0; clr_ovf = 1'b0; main_din = 8'h00; snd_din = 8'h00;
        do_reset();
        do_reset();
        chk_en = 1'b1;

        // Reset state
        chk("rst m2s_count", 0, 32'(a_mcnt[0]), 32'd0);
        chk("rst snd_dout",  0, 32'(a_sdout[0]), 32'd0);
        chk("rst snd_irq_n", 2, 32'(a_irqn[2]), 32'd1);
        chk("rst snd_full",  0, 32'(a_sfull[0]), 32'd0);

        // Basic transfer
        push_m(8'h11); push_m(8'h22); push_m(8'h33);
        chk("basic count", 0, 32'(a_mcnt[0]), 32'd3);
        chk("basic head",  0, 32'(a_sdout[0]), 32'h11);
        pop_s();
        chk("basic pop1", 0, 32'(a_sdout[0]), 32'h22);
        pop_s();
        chk("basic pop2", 0, 32'(a_sdout[0]), 32'h33);
        pop_s();
        chk("basic empty count", 0, 32'(a_mcnt[0]), 32'd0);
        chk("basic hold dout",   0, 32'(a_sdout[0]), 32'h33);

        // Overflow and clear
        do_reset();
        for (int v = 0; v < 5; v++) push_m(8'(8'hA0 + v));
        chk("ovf full", 0, 32'(a_mfull[0]), 32'd1);
        chk("ovf flag", 0, 32'(a_ovf[0]), 32'b01);
        for (int v = 0; v < 4; v++) begin
            chk("ovf pop order", 0, 32'(a_sdout[0]), 32'(8'hA0 + v));
            pop_s();
        end
        chk("ovf drained", 0, 32'(a_mcnt[0]), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovf cleared", 0, 32'(a_ovf[0]), 32'd0);

        // Latch mode (DEPTH=1, OVERWRITE=1)
        do_reset();
        push_m(8'h05); push_m(8'h06);
        chk("latch dout",  1, 32'(a_sdout[1]), 32'h06);
        chk("latch count", 1, 32'(a_mcnt[1]), 32'd1);
        chk("latch ovf0",  1, 32'(a_ovf[1][0]), 32'd1);

        // Simultaneous push/pop on full and on empty
        do_reset();
        for (int v = 1; v <= 4; v++) push_m(8'(v));
        drive(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("simul full count", 0, 32'(a_mcnt[0]), 32'd4);
        chk("simul full ovf",   0, 32'(a_ovf[0]), 32'd0);
        pop_s(); pop_s(); pop_s();
        chk("simul last out", 0, 32'(a_sdout[0]), 32'h77);
        pop_s();
        drive(1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("simul empty count", 0, 32'(a_mcnt[0]), 32'd1);
        chk("simul empty head",  0, 32'(a_sdout[0]), 32'h42);

        // IRQ modes
        do_reset();
        push_m(8'h01);
        chk("irq1 push", 2, 32'(a_irqn[2]), 32'd0);
        chk("irq0 push", 0, 32'(a_irqn[0]), 32'd0);
        pop_s();
        chk("irq1 pop",  2, 32'(a_irqn[2]), 32'd0);
        chk("irq0 pop",  0, 32'(a_irqn[0]), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("irq1 ack",  2, 32'(a_irqn[2]), 32'd1);
        drive(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("irq1 ack+push", 2, 32'(a_irqn[2]), 32'd0);

        // Reset mid-stream, with strobes active during the reset cycle
        do_reset();
        for (int v = 0; v < 3; v++)
            drive(1'b1, 8'(8'h10 + v), 1'b0, 1'b1, 8'(8'h20 + v), 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid s2m queued", 0, 32'(a_scnt[0]), 32'd3);
        drive(1'b1, 8'hEE, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < c_N; i++) begin
            chk("mid m2s_count", i, 32'(a_mcnt[i]), 32'd0);
            chk("mid s2m_count", i, 32'(a_scnt[i]), 32'd0);
            chk("mid snd_dout",  i, 32'(a_sdout[i]), 32'd0);
            chk("mid main_dout", i, 32'(a_mdout[i]), 32'd0);
            chk("mid snd_irq_n", i, 32'(a_irqn[i]), 32'd1);
        end
        push_m(8'h5A);
        chk("mid first head", 0, 32'(a_sdout[0]), 32'h5A);

        // Randomized traffic, alternating fill-biased and drain-biased phases
        for (int c = 0; c < 2400; c++) begin
            int wp = ((c / 150) % 2 == 0) ? 70 : 30;
            drive(1'($urandom_range(0, 99) < wp), 8'($urandom),
                  1'($urandom_range(0, 99) < 100 - wp),
                  1'($urandom_range(0, 99) < wp), 8'($urandom),
                  1'($urandom_range(0, 99) < 100 - wp),
                  1'($urandom_range(0, 99) < 10),
                  1'($urandom_range(0, 99) < 5),
                  1'($urandom_range(0, 299) != 0));
        end

        @(negedge clk_sys);
        @(negedge clk_sys);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
